// File: rtl/aqp_ovl_text_render.sv
// Scanline text renderer: emits one 4-bit colour index per clock for a COLUMNS x ROWS character field.
// First pixel 5 cycles after line_start; no backpressure (the output is a free-running pixel stream).
module aqp_ovl_text_render #(
    parameter int COLUMNS = 40,
    parameter int ROWS    = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        line_start,
    output logic [9:0]  text_addr,
    input  logic [15:0] text_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        pix_valid,
    output logic [3:0]  pix_color,
    output logic        line_done
);
    localparam int CW = $clog2(COLUMNS + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_END  = CW'(COLUMNS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [9:0]    COL_STEP = 10'(COLUMNS);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ACTIVE,
        DONE,
        EXHAUSTED
    } state_t;

    state_t        state;
    logic [2:0]    scan;
    logic [RW-1:0] row;
    logic [9:0]    line_base;
    logic [CW-1:0] col;
    logic [2:0]    tick;

    logic          s1_vld;
    logic          s2_vld;
    logic          s3_vld;
    logic          s4_vld;
    logic [7:0]    attr_s3;
    logic [7:0]    attr_s4;
    logic [7:0]    cur_attr;
    logic [7:0]    shift;
    logic [2:0]    px_cnt;

    logic [2:0]    adv_scan;
    logic [RW-1:0] adv_row;
    logic [9:0]    adv_base;
    logic          adv_last;
    logic          advance;
    logic          flush;
    logic          start;
    logic [9:0]    start_base;
    logic          line_end;

    always_comb begin
        adv_scan = scan + 3'd1;
        adv_row  = row;
        adv_base = line_base;
        if (scan == 3'd7) begin
            adv_row  = row + RW'(1);
            adv_base = line_base + COL_STEP;
        end
        adv_last = (row == ROW_LAST) && (scan == 3'd7);

        advance = 1'b0;
        flush   = 1'b0;
        start   = 1'b0;
        if (frame_start) begin
            flush = 1'b1;
            start = line_start;
        end else begin
            case (state)
                IDLE: start = line_start;
                FETCH, ACTIVE: begin
                    // A new line request abandons the current one but still consumes its scanline.
                    if (line_start) begin
                        flush   = 1'b1;
                        advance = 1'b1;
                        start   = !adv_last;
                    end
                end
                DONE: begin
                    advance = 1'b1;
                    start   = line_start && !adv_last;
                end
                default: ;
            endcase
        end

        start_base = frame_start ? 10'd0 : (advance ? adv_base : line_base);
        line_end   = (state == ACTIVE) && pix_valid && (px_cnt == 3'd0) && !s4_vld;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            scan      <= '0;
            row       <= '0;
            line_base <= '0;
            col       <= '0;
            tick      <= '0;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            s3_vld    <= 1'b0;
            s4_vld    <= 1'b0;
            attr_s3   <= '0;
            attr_s4   <= '0;
            cur_attr  <= '0;
            shift     <= '0;
            px_cnt    <= '0;
            text_addr <= '0;
            font_addr <= '0;
            pix_valid <= 1'b0;
            pix_color <= '0;
            line_done <= 1'b0;
        end else begin
            line_done <= 1'b0;
            s1_vld    <= 1'b0;
            s2_vld    <= s1_vld & ~flush;
            s3_vld    <= s2_vld & ~flush;
            s4_vld    <= s3_vld & ~flush;

            if (s2_vld && !flush) begin
                font_addr <= {text_data[7:0], scan};
                attr_s3   <= text_data[15:8];
            end
            if (s3_vld && !flush) begin
                attr_s4 <= attr_s3;
            end

            // Glyph byte lands exactly on the character boundary, so the first bit goes straight out.
            if (flush) begin
                pix_valid <= 1'b0;
                pix_color <= '0;
                px_cnt    <= '0;
            end else if (s4_vld) begin
                pix_valid <= 1'b1;
                pix_color <= font_data[7] ? attr_s4[3:0] : attr_s4[7:4];
                shift     <= {font_data[6:0], 1'b0};
                cur_attr  <= attr_s4;
                px_cnt    <= 3'd7;
            end else if (px_cnt != 3'd0) begin
                pix_color <= shift[7] ? cur_attr[3:0] : cur_attr[7:4];
                shift     <= {shift[6:0], 1'b0};
                px_cnt    <= px_cnt - 3'd1;
            end else begin
                pix_valid <= 1'b0;
                pix_color <= '0;
            end

            if (frame_start) begin
                scan      <= '0;
                row       <= '0;
                line_base <= '0;
            end else if (advance && !adv_last) begin
                scan      <= adv_scan;
                row       <= adv_row;
                line_base <= adv_base;
            end

            if (start) begin
                state     <= FETCH;
                text_addr <= start_base;
                s1_vld    <= 1'b1;
                col       <= CW'(1);
                tick      <= '0;
            end else if (frame_start) begin
                state <= IDLE;
                col   <= '0;
            end else if (advance && adv_last) begin
                state <= EXHAUSTED;
                col   <= '0;
            end else begin
                case (state)
                    FETCH, ACTIVE: begin
                        tick <= tick + 3'd1;
                        if (tick == 3'd7 && col != COL_END) begin
                            text_addr <= line_base + 10'(col);
                            col       <= col + CW'(1);
                            s1_vld    <= 1'b1;
                        end
                        if (state == FETCH && s4_vld) begin
                            state <= ACTIVE;
                        end
                        if (line_end) begin
                            state     <= DONE;
                            line_done <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        col   <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
